// File: rtl/fc_accumulator.sv
// fc_accumulator: dense layer over one pooled frame; parallel per-class MACs, then serial biased scores.
module fc_accumulator #(
  parameter int DATA_WIDTH   = 22,
  parameter int WEIGHT_WIDTH = 8,
  parameter int NUM_IN       = 225,
  parameter int NUM_OUT      = 4,
  parameter int ACC_WIDTH    = 40
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               in_valid,
  input  logic signed [DATA_WIDTH-1:0]       in_data,
  output logic                               in_ready,
  input  logic                               wt_we,
  input  logic [$clog2(NUM_OUT)-1:0]         wt_sel,
  input  logic [$clog2(NUM_IN)-1:0]          wt_addr,
  input  logic signed [WEIGHT_WIDTH-1:0]     wt_data,
  input  logic                               bias_we,
  input  logic signed [ACC_WIDTH-1:0]        bias_data,
  output logic                               out_valid,
  output logic [$clog2(NUM_OUT)-1:0]         out_idx,
  output logic signed [ACC_WIDTH-1:0]        out_data,
  output logic                               done_signal,
  output logic                               overrun
);
  localparam int PW = DATA_WIDTH + WEIGHT_WIDTH;
  localparam int IW = $clog2(NUM_IN);
  localparam int OW = $clog2(NUM_OUT);
  localparam int CW = $clog2(NUM_OUT) + 1;
  typedef enum logic [2:0] {IDLE, ACCUM, DRAIN, OUTPUT, DONE} state_t;
  state_t state, state_n;
  logic [IW-1:0] in_cnt, s_idx;
  logic [CW-1:0] ph;
  logic signed [DATA_WIDTH-1:0] s_data;
  logic s_valid, p_valid, accept, idle, last;
  logic signed [WEIGHT_WIDTH-1:0] w_mem [NUM_OUT][NUM_IN];
  logic signed [ACC_WIDTH-1:0] b_mem [NUM_OUT];
  logic signed [PW-1:0] prod [NUM_OUT];
  logic signed [ACC_WIDTH-1:0] acc [NUM_OUT];

  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_n;

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (accept) state_n = last ? DRAIN : ACCUM;
      ACCUM:   if (accept && last) state_n = DRAIN;
      DRAIN:   if (ph == CW'(1)) state_n = OUTPUT;
      OUTPUT:  if (ph == CW'(NUM_OUT - 1)) state_n = DONE;
      default: state_n = IDLE;
    endcase
  end

  // the done_signal cycle still belongs to the finished frame, so IDLE only opens after it
  always_comb begin
    idle     = state == IDLE && !done_signal;
    in_ready = idle || state == ACCUM;
    accept   = in_valid && in_ready;
    last     = in_cnt == IW'(NUM_IN - 1);
  end

  always_ff @(posedge clk) begin
    if (idle && wt_we && int'(wt_addr) < NUM_IN && int'(wt_sel) < NUM_OUT) w_mem[wt_sel][wt_addr] <= wt_data;
    if (idle && bias_we && int'(wt_sel) < NUM_OUT) b_mem[wt_sel] <= bias_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      in_cnt      <= '0;
      s_idx       <= '0;
      s_data      <= '0;
      ph          <= '0;
      s_valid     <= 1'b0;
      p_valid     <= 1'b0;
      out_valid   <= 1'b0;
      out_idx     <= '0;
      out_data    <= '0;
      done_signal <= 1'b0;
      overrun     <= 1'b0;
      for (int k = 0; k < NUM_OUT; k++) begin
        prod[k] <= '0;
        acc[k]  <= '0;
      end
    end else begin
      s_valid <= accept;
      if (accept) begin
        s_data <= in_data;
        s_idx  <= in_cnt;
        in_cnt <= last ? '0 : in_cnt + IW'(1);
      end
      p_valid <= s_valid;
      for (int k = 0; k < NUM_OUT; k++) begin
        if (s_valid) prod[k] <= PW'(s_data) * PW'(w_mem[k][s_idx]);
        if (state == IDLE && accept) acc[k] <= '0;
        else if (p_valid) acc[k] <= acc[k] + ACC_WIDTH'(prod[k]);
      end
      ph <= ((state == DRAIN && ph != CW'(1)) || (state == OUTPUT && ph != CW'(NUM_OUT - 1))) ? ph + CW'(1) : '0;
      out_valid <= state == OUTPUT;
      if (state == OUTPUT) begin
        out_idx  <= ph[OW-1:0];
        out_data <= acc[ph[OW-1:0]] + b_mem[ph[OW-1:0]];
      end
      done_signal <= state == DONE;
      overrun     <= overrun | (in_valid & ~in_ready);
    end
  end
endmodule

// File: tb/tb_fc_accumulator.sv
// tb_fc_accumulator: scoreboard bench for fc_accumulator with a dot-product reference model.
module tb_fc_accumulator;
  localparam int DW = 22, WW = 8, NI = 225, NO = 4, AW = 40;
  logic clk = 0, rst = 1, in_valid = 0, wt_we = 0, bias_we = 0;
  logic signed [DW-1:0] in_data = '0;
  logic [1:0] wt_sel = '0;
  logic [7:0] wt_addr = '0;
  logic signed [WW-1:0] wt_data = '0;
  logic signed [AW-1:0] bias_data = '0;
  logic in_ready, out_valid, done_signal, overrun;
  logic [1:0] out_idx;
  logic signed [AW-1:0] out_data;

  fc_accumulator dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .wt_we(wt_we), .wt_sel(wt_sel), .wt_addr(wt_addr), .wt_data(wt_data),
    .bias_we(bias_we), .bias_data(bias_data), .out_valid(out_valid), .out_idx(out_idx),
    .out_data(out_data), .done_signal(done_signal), .overrun(overrun)
  );

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {int idx; longint val; int c;} exp_t;
  exp_t exp_q[$];
  exp_t e;
  int done_q[$];
  int n_chk = 0, n_fail = 0;
  longint w_m[NO][NI];
  longint b_m[NO];
  longint fd[NI];
  longint wv[NO];
  longint bv[NO];
  longint last_score;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) if (!rst) begin
    if (out_valid) begin
      if (exp_q.size() == 0) chk("unexpected_score", 1, 0);
      else begin
        e = exp_q.pop_front();
        chk("score_idx", longint'(out_idx), longint'(e.idx));
        chk("score_val", longint'(out_data), e.val);
        chk("score_cycle", longint'(cyc), longint'(e.c));
      end
    end
    if (done_signal) begin
      if (done_q.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        chk("done_cycle", longint'(cyc), longint'(done_q.pop_front()));
        chk("in_ready_in_done", longint'(in_ready), 0);
      end
    end
  end

  // expected scores are plain dot products of the frame with each class's weights, plus bias
  task automatic push_exp(input int edge_e);
    longint s;
    for (int k = 0; k < NO; k++) begin
      s = b_m[k];
      for (int i = 0; i < NI; i++) s += fd[i] * w_m[k][i];
      exp_q.push_back('{k, s, edge_e + 3 + k});
      last_score = s;
    end
    done_q.push_back(edge_e + 3 + NO);
  endtask

  task automatic load(input bit rnd);
    logic signed [WW-1:0] w;
    logic signed [AW-1:0] b;
    for (int k = 0; k < NO; k++)
      for (int a = 0; a < NI; a++) begin
        @(negedge clk);
        w = rnd ? WW'($urandom) : WW'(wv[k]);
        b = rnd ? AW'(signed'($urandom)) : AW'(bv[k]);
        wt_we = 1; wt_sel = 2'(k); wt_addr = 8'(a); wt_data = w;
        bias_we = (a == 0); bias_data = b;
        w_m[k][a] = longint'(w);
        if (a == 0) b_m[k] = longint'(b);
      end
    @(negedge clk);
    wt_we = 0; bias_we = 0;
  endtask

  task automatic fill(input bit rnd, input longint v);
    logic signed [DW-1:0] d;
    for (int i = 0; i < NI; i++) begin
      d = rnd ? DW'($urandom) : DW'(v);
      fd[i] = longint'(d);
    end
  endtask

  // mode: 0 back-to-back, 1 pooling cadence, 2 random gaps; ovr: pulse in_valid that many cycles after the last sample
  task automatic send(input int mode, input int ovr, input int inj);
    int g, t;
    for (int i = 0; i < NI; i++) begin
      @(negedge clk);
      in_valid = 1; in_data = DW'(fd[i]);
      wt_we = (i == inj); wt_sel = 0; wt_addr = 5; wt_data = 77;
      if (i == NI - 1) push_exp(cyc + 1);
      g = (i == NI - 1) ? 0 : mode == 0 ? 0 : mode == 1 ? ((i % 15 == 14) ? 31 : 1) : int'($urandom_range(0, 3));
      repeat (g) begin
        @(negedge clk);
        in_valid = 0; wt_we = 0;
      end
    end
    for (int j = 1; j <= ovr + 1; j++) begin
      @(negedge clk);
      in_valid = (j == ovr); wt_we = 0;
    end
    t = 0;
    while (done_q.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (done_q.size() != 0) begin
      chk("frame_timeout", 1, 0);
      done_q.delete();
      exp_q.delete();
    end
    repeat (2) @(negedge clk);
    chk("out_data_hold", longint'(out_data), last_score);
  endtask

  task automatic set_wb(input longint w0, w1, w2, w3, b3);
    wv = '{w0, w1, w2, w3};
    bv = '{0, 0, 0, b3};
    load(0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_out_valid", longint'(out_valid), 0);
    chk("rst_out_idx", longint'(out_idx), 0);
    chk("rst_out_data", longint'(out_data), 0);
    chk("rst_done", longint'(done_signal), 0);
    chk("rst_overrun", longint'(overrun), 0);
    rst = 0;
    @(negedge clk);
    chk("idle_in_ready", longint'(in_ready), 1);
    set_wb(1, 1, 1, 1, 0);
    fill(0, 1);
    send(0, 0, -1);
    set_wb(-1, 2, 0, 1, -5);
    fill(0, -100);
    send(0, 0, -1);
    set_wb(1, 1, 1, 1, 0);
    fill(0, 1);
    send(1, 0, -1);
    chk("cadence_no_overrun", longint'(overrun), 0);
    set_wb(-128, -128, -128, -128, 0);
    fill(0, -2097152);
    send(0, 0, -1);
    set_wb(127, 127, 127, 127, 0);
    fill(0, 2097151);
    send(2, 0, -1);
    load(1);
    for (int r = 0; r < 2; r++) begin
      fill(1, 0);
      send(2, 0, -1);
    end
    chk("no_overrun_yet", longint'(overrun), 0);
    fill(1, 0);
    send(0, 8, -1);
    chk("overrun_done_cycle", longint'(overrun), 1);
    fill(1, 0);
    send(2, 0, -1);
    set_wb(1, 1, 1, 1, 0);
    fill(0, 1);
    send(0, 4, 50);
    chk("overrun_output", longint'(overrun), 1);
    send(0, 0, -1);
    chk("overrun_sticky", longint'(overrun), 1);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      in_valid = 1; in_data = 1;
    end
    @(negedge clk);
    in_valid = 0; rst = 1;
    @(negedge clk);
    rst = 0;
    chk("midrst_overrun", longint'(overrun), 0);
    chk("midrst_out_valid", longint'(out_valid), 0);
    chk("midrst_in_ready", longint'(in_ready), 1);
    send(0, 0, -1);
    chk("final_queue_empty", longint'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
